// File: rtl/l2_arbiter_pkg.sv
// Shared definitions for the two-port L2 arbiter: FSM encoding, port ids,
// default widths and a small request-decode helper.
package l2_arbiter_pkg;

  // Default widths: block address and cache line
  localparam int ADDR_W_DEF = 28;
  localparam int DATA_W_DEF = 128;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Port identifiers, also used as the last_grant encoding
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  // Decoded view of one L1 port's request lines
  typedef struct packed {
    logic req;
    logic wr;
  } port_req_t;

  // A port requests on read or write; write dominates when both are high
  function automatic port_req_t decode_req(input logic rd, input logic wr);
    port_req_t r;
    r.req = rd | wr;
    r.wr  = wr;
    return r;
  endfunction

endpackage

// File: rtl/l2_arbiter_arb_rr2.sv
// Two-way round-robin grant decision. Purely combinational: a lone
// requester always wins, on a tie the port that was not granted last wins.
module arb_rr2
  import l2_arbiter_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic last_grant,
  output logic grant_vld,
  output logic grant_port
);

  // Pick the winner from the current requests and the previous grant
  always_comb begin
    grant_vld  = i_req | d_req;
    grant_port = PORT_I;
    if (i_req && d_req) begin
      grant_port = (last_grant == PORT_I) ? PORT_D : PORT_I;
    end else if (d_req) begin
      grant_port = PORT_D;
    end
  end

endmodule

// File: rtl/l2_arbiter.sv
// Arbiter sharing one L2 port between the I-side and D-side L1 caches.
// One transaction at a time: IDLE grants, BUSY holds the L2 request until
// mem_ready, DONE presents a single-cycle ready pulse to the winner.
// All outputs come straight from flops.
module l2_arbiter
  import l2_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              proc_reset,
  // I-side L1
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  // D-side L1
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  // Shared L2
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  // Completed-transaction counters
  output logic [15:0]       i_grant_cnt,
  output logic [15:0]       d_grant_cnt
);

  logic [1:0]        state;
  logic              last_grant;
  logic              gnt_port_p1;

  port_req_t         i_rq;
  port_req_t         d_rq;
  logic              grant_vld;
  logic              grant_port;

  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic              take_grant;
  logic              complete;

  assign i_rq = decode_req(i_read, i_write);
  assign d_rq = decode_req(d_read, d_write);

  arb_rr2 u_arb (
    .i_req      (i_rq.req),
    .d_req      (d_rq.req),
    .last_grant (last_grant),
    .grant_vld  (grant_vld),
    .grant_port (grant_port)
  );

  // Steer the winning port's request fields toward the L2 request flops
  always_comb begin
    sel_write = i_rq.wr;
    sel_addr  = i_addr;
    sel_wdata = i_wdata;
    if (grant_port == PORT_D) begin
      sel_write = d_rq.wr;
      sel_addr  = d_addr;
      sel_wdata = d_wdata;
    end
  end

  // Grants are only taken in IDLE; completions only count in BUSY, so a
  // stray mem_ready in IDLE or DONE has no effect.
  assign take_grant = (state == ST_IDLE) && grant_vld;
  assign complete   = (state == ST_BUSY) && mem_ready;

  // FSM and round-robin history
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state       <= ST_IDLE;
      last_grant  <= PORT_I;
      gnt_port_p1 <= PORT_I;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take_grant) begin
            gnt_port_p1 <= grant_port;
            state       <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (complete) begin
            last_grant <= gnt_port_p1;
            state      <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // L2 request: captured on grant, frozen through BUSY, strobes dropped on
  // completion. Address and line stay put afterwards; reads send a zero line.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (take_grant) begin
      mem_read  <= ~sel_write;
      mem_write <= sel_write;
      mem_addr  <= sel_addr;
      mem_wdata <= sel_write ? sel_wdata : '0;
    end else if (complete) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end
  end

  // Return path: the ready pulse lives exactly in the DONE cycle, and each
  // port's rdata holds until that port's next completion.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      i_ready <= complete && (gnt_port_p1 == PORT_I);
      d_ready <= complete && (gnt_port_p1 == PORT_D);
      if (complete && (gnt_port_p1 == PORT_I)) i_rdata <= mem_rdata;
      if (complete && (gnt_port_p1 == PORT_D)) d_rdata <= mem_rdata;
    end
  end

  // Per-port completed-transaction counters, free-running 16-bit wrap
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      i_grant_cnt <= 16'd0;
      d_grant_cnt <= 16'd0;
    end else if (complete) begin
      if (gnt_port_p1 == PORT_I) i_grant_cnt <= i_grant_cnt + 16'd1;
      else                       d_grant_cnt <= d_grant_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench for l2_arbiter: single reads, tie-break order, alternation
// under contention, read+write precedence, reset mid-transaction and the
// grant counter wrap.
module tb_l2_arbiter;

  localparam int AW = 28;
  localparam int DW = 128;

  logic          clk;
  logic          proc_reset;
  logic          i_read, i_write, d_read, d_write;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] i_wdata, d_wdata;
  logic [DW-1:0] i_rdata, d_rdata;
  logic          i_ready, d_ready;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic [15:0]   i_grant_cnt, d_grant_cnt;

  int checks   = 0;
  int failures = 0;
  int i_pulses = 0;
  int d_pulses = 0;
  int overlaps = 0;

  l2_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .proc_reset  (proc_reset),
    .i_read      (i_read),
    .i_write     (i_write),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .i_rdata     (i_rdata),
    .i_ready     (i_ready),
    .d_read      (d_read),
    .d_write     (d_write),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_ready     (d_ready),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .i_grant_cnt (i_grant_cnt),
    .d_grant_cnt (d_grant_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ready-pulse bookkeeping
  always @(negedge clk) begin
    if (i_ready) i_pulses = i_pulses + 1;
    if (d_ready) d_pulses = d_pulses + 1;
    if (i_ready && d_ready) overlaps = overlaps + 1;
  end

  task automatic clear_inputs();
    i_read = 0; i_write = 0; i_addr = '0; i_wdata = '0;
    d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0; mem_ready = 0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    proc_reset = 1;
    repeat (2) @(negedge clk);
    proc_reset = 0;
    @(negedge clk);
  endtask

  // Wait (bounded) until the arbiter raises an L2 strobe
  task automatic wait_mem_req(output bit ok);
    ok = 0;
    for (int n = 0; n < 20; n++) begin
      if (mem_read || mem_write) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // L2 model: answer lat cycles after the strobe is seen, one-cycle ready
  task automatic pulse_ready(input int lat, input logic [DW-1:0] data);
    repeat (lat - 1) @(negedge clk);
    mem_ready = 1; mem_rdata = data;
    @(negedge clk);
    mem_ready = 0; mem_rdata = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    proc_reset = 1;
    #1;
    checks++;
    if ({mem_read, mem_write, i_ready, d_ready} !== 4'b0000) begin
      failures++; $display("FAIL reset_strobes got=%b exp=0000", {mem_read, mem_write, i_ready, d_ready});
    end
    checks++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      failures++; $display("FAIL reset_mem_bus got addr=%h wdata=%h exp=0", mem_addr, mem_wdata);
    end
    checks++;
    if (i_rdata !== '0 || d_rdata !== '0 || i_grant_cnt !== 16'd0 || d_grant_cnt !== 16'd0) begin
      failures++; $display("FAIL reset_rdata_cnt got %h %h %h %h exp=0", i_rdata, d_rdata, i_grant_cnt, d_grant_cnt);
    end
    repeat (2) @(negedge clk);
    proc_reset = 0;
    @(negedge clk);
  endtask

  task automatic test_d_read();
    bit ok;
    d_read = 1; d_addr = 28'h0000010;
    wait_mem_req(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL d_read_timeout got=none exp=mem_read"); end
    checks++;
    if ({mem_read, mem_write} !== 2'b10 || mem_addr !== 28'h0000010 || mem_wdata !== '0) begin
      failures++; $display("FAIL d_read_req got rd=%b wr=%b addr=%h exp rd=1 wr=0 addr=0000010", mem_read, mem_write, mem_addr);
    end
    pulse_ready(3, {16{8'hA5}});
    checks++;
    if (d_ready !== 1'b1 || i_ready !== 1'b0 || d_rdata !== {16{8'hA5}}) begin
      failures++; $display("FAIL d_read_done got d_ready=%b i_ready=%b d_rdata=%h exp 1 0 a5..a5", d_ready, i_ready, d_rdata);
    end
    checks++;
    if (d_grant_cnt !== 16'd1 || i_grant_cnt !== 16'd0) begin
      failures++; $display("FAIL d_read_cnt got d=%0d i=%0d exp d=1 i=0", d_grant_cnt, i_grant_cnt);
    end
    d_read = 0;
    @(negedge clk);
    checks++;
    if (d_ready !== 1'b0 || mem_read !== 1'b0 || d_rdata !== {16{8'hA5}}) begin
      failures++; $display("FAIL d_read_after got d_ready=%b mem_read=%b d_rdata=%h exp 0 0 a5..a5", d_ready, mem_read, d_rdata);
    end
  endtask

  task automatic test_tie();
    bit ok;
    int i0;
    apply_reset();
    i0 = i_pulses;
    i_read = 1; i_addr = 28'h0000100;
    d_read = 1; d_addr = 28'h0000200;
    wait_mem_req(ok);
    checks++;
    if (!ok || mem_addr !== 28'h0000200) begin
      failures++; $display("FAIL tie_first got ok=%b addr=%h exp addr=0000200", ok, mem_addr);
    end
    pulse_ready(1, 128'h11);
    checks++;
    if (d_ready !== 1'b1 || i_ready !== 1'b0 || d_rdata !== 128'h11) begin
      failures++; $display("FAIL tie_d_done got d_ready=%b i_ready=%b d_rdata=%h exp 1 0 11", d_ready, i_ready, d_rdata);
    end
    d_read = 0;
    @(negedge clk);
    wait_mem_req(ok);
    checks++;
    if (!ok || mem_addr !== 28'h0000100 || mem_read !== 1'b1) begin
      failures++; $display("FAIL tie_second got ok=%b addr=%h rd=%b exp addr=0000100 rd=1", ok, mem_addr, mem_read);
    end
    pulse_ready(2, 128'h22);
    checks++;
    if (i_ready !== 1'b1 || d_ready !== 1'b0 || i_rdata !== 128'h22 || d_rdata !== 128'h11) begin
      failures++; $display("FAIL tie_i_done got i_ready=%b d_ready=%b i_rdata=%h d_rdata=%h exp 1 0 22 11", i_ready, d_ready, i_rdata, d_rdata);
    end
    i_read = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (i_pulses - i0 !== 1 || overlaps !== 0) begin
      failures++; $display("FAIL tie_pulses got i_pulses=%0d overlaps=%0d exp 1 0", i_pulses - i0, overlaps);
    end
  endtask

  task automatic test_alternate();
    bit ok;
    bit exp_d;
    i_read = 1; i_addr = 28'h0000100;
    d_write = 1; d_addr = 28'h0000300; d_wdata = 128'h1234;
    for (int r = 0; r < 6; r++) begin
      exp_d = (r % 2 == 0);
      wait_mem_req(ok);
      checks++;
      if (!ok || mem_addr !== (exp_d ? 28'h0000300 : 28'h0000100)) begin
        failures++; $display("FAIL alt_grant_%0d got ok=%b addr=%h exp_d=%b", r, ok, mem_addr, exp_d);
      end
      checks++;
      if (exp_d ? ({mem_read, mem_write} !== 2'b01 || mem_wdata !== 128'h1234)
                : ({mem_read, mem_write} !== 2'b10 || mem_wdata !== '0)) begin
        failures++; $display("FAIL alt_op_%0d got rd=%b wr=%b wdata=%h exp_d=%b", r, mem_read, mem_write, mem_wdata, exp_d);
      end
      pulse_ready(1, DW'(r + 1));
      checks++;
      if (exp_d ? (d_ready !== 1'b1 || i_ready !== 1'b0 || d_rdata !== DW'(r + 1))
                : (i_ready !== 1'b1 || d_ready !== 1'b0 || i_rdata !== DW'(r + 1))) begin
        failures++; $display("FAIL alt_done_%0d got i_ready=%b d_ready=%b i_rdata=%h d_rdata=%h exp_d=%b", r, i_ready, d_ready, i_rdata, d_rdata, exp_d);
      end
      if (exp_d) d_write = 0; else i_read = 0;
      @(negedge clk);
      if (r < 5) begin
        if (exp_d) d_write = 1; else i_read = 1;
      end
    end
    i_read = 0; d_write = 0;
    @(negedge clk);
    checks++;
    if (i_grant_cnt !== 16'd4 || d_grant_cnt !== 16'd4 || overlaps !== 0) begin
      failures++; $display("FAIL alt_cnt got i=%0d d=%0d overlaps=%0d exp 4 4 0", i_grant_cnt, d_grant_cnt, overlaps);
    end
  endtask

  task automatic test_rw_and_stray_ready();
    bit ok;
    // mem_ready while idle must be ignored
    mem_ready = 1; mem_rdata = {8{16'hFFFF}};
    repeat (2) @(negedge clk);
    mem_ready = 0; mem_rdata = '0;
    @(negedge clk);
    checks++;
    if (d_ready !== 1'b0 || i_ready !== 1'b0 || d_rdata !== 128'h5 || d_grant_cnt !== 16'd4 || i_grant_cnt !== 16'd4) begin
      failures++; $display("FAIL stray_ready got d_ready=%b i_ready=%b d_rdata=%h cnt=%0d/%0d exp 0 0 5 4/4", d_ready, i_ready, d_rdata, d_grant_cnt, i_grant_cnt);
    end
    d_read = 1; d_write = 1; d_addr = 28'h0000055; d_wdata = 128'hBEEF;
    wait_mem_req(ok);
    checks++;
    if (!ok || {mem_read, mem_write} !== 2'b01 || mem_wdata !== 128'hBEEF || mem_addr !== 28'h0000055) begin
      failures++; $display("FAIL rw_as_write got rd=%b wr=%b wdata=%h addr=%h exp rd=0 wr=1 beef 55", mem_read, mem_write, mem_wdata, mem_addr);
    end
    pulse_ready(2, 128'h77);
    checks++;
    if (d_ready !== 1'b1 || d_grant_cnt !== 16'd5) begin
      failures++; $display("FAIL rw_done got d_ready=%b cnt=%0d exp 1 5", d_ready, d_grant_cnt);
    end
    d_read = 0; d_write = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_busy();
    bit ok;
    int d0;
    d_read = 1; d_addr = 28'h0000066;
    wait_mem_req(ok);
    @(negedge clk);
    d0 = d_pulses;
    proc_reset = 1;
    #1;
    checks++;
    if (!ok || mem_read !== 1'b0 || d_ready !== 1'b0) begin
      failures++; $display("FAIL rst_busy_abort got ok=%b mem_read=%b d_ready=%b exp 1 0 0", ok, mem_read, d_ready);
    end
    checks++;
    if (i_grant_cnt !== 16'd0 || d_grant_cnt !== 16'd0 || d_rdata !== '0) begin
      failures++; $display("FAIL rst_busy_clear got i=%0d d=%0d d_rdata=%h exp 0 0 0", i_grant_cnt, d_grant_cnt, d_rdata);
    end
    @(negedge clk);
    d_read = 0;
    proc_reset = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (d_pulses !== d0 || mem_read !== 1'b0) begin
      failures++; $display("FAIL rst_busy_no_ready got pulses=%0d mem_read=%b exp %0d 0", d_pulses, mem_read, d0);
    end
    i_read = 1; i_addr = 28'h0000040;
    wait_mem_req(ok);
    checks++;
    if (!ok || mem_read !== 1'b1 || mem_addr !== 28'h0000040) begin
      failures++; $display("FAIL rst_busy_next got ok=%b rd=%b addr=%h exp 1 1 0000040", ok, mem_read, mem_addr);
    end
    pulse_ready(1, 128'h99);
    checks++;
    if (i_ready !== 1'b1 || i_rdata !== 128'h99 || i_grant_cnt !== 16'd1) begin
      failures++; $display("FAIL rst_busy_served got i_ready=%b i_rdata=%h cnt=%0d exp 1 99 1", i_ready, i_rdata, i_grant_cnt);
    end
    i_read = 0;
    @(negedge clk);
  endtask

  task automatic test_cnt_wrap();
    bit ok;
    logic [15:0] exp_cnt [2];
    exp_cnt[0] = 16'hFFFF;
    exp_cnt[1] = 16'h0000;
    // preload close to wrap rather than replaying 65534 transactions
    force dut.i_grant_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.i_grant_cnt;
    @(negedge clk);
    for (int n = 0; n < 2; n++) begin
      i_read = 1; i_addr = AW'(28'h0000700 + n);
      wait_mem_req(ok);
      pulse_ready(1, DW'(n));
      checks++;
      if (!ok || i_ready !== 1'b1 || i_grant_cnt !== exp_cnt[n]) begin
        failures++; $display("FAIL cnt_wrap_%0d got ok=%b i_ready=%b cnt=%h exp %h", n, ok, i_ready, i_grant_cnt, exp_cnt[n]);
      end
      i_read = 0;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_d_read();
    test_tie();
    test_alternate();
    test_rw_and_stray_ready();
    test_reset_busy();
    test_cnt_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
